exe_stage_mdu: RTL and testbench
================================

// Module: exe_stage_mdu
// PURPOSE
//  Parametrised execute stage for the 5-stage pipeline (decode -> execute -> memory) with a multi-cycle mul/div unit.
//  Holds HI/LO, generates sized store byte-enables and drives the forwarding/load-hazard outputs back to decode.
//  Stalls via the valid/allowin handshake while the mul/div unit is busy.
// PARAMETERS
//  XLEN      32  datapath width; must be a multiple of 8 and >=16
//  MUL_LAT   4   mult/multu cycles from issue to HI/LO write (>=1)
//  DIV_LAT   XLEN  div/divu cycles, restoring radix-2; fixed to XLEN
// PORTS
//  clk             in   1        clock; all state on rising edge
//  resetn          in   1        asynchronous, active-low reset
//  ds_to_es_valid  in   1        decode offers an instruction
//  es_allowin      out  1        !es_valid || (es_ready_go && ms_allowin)
//  ds_alu_op       in   12       one-hot ALU op (existing alu encoding)
//  ds_mdu_op       in   3        0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi/mtlo (sel by ds_dest[0])
//  ds_src1/ds_src2 in   XLEN     ALU operands, already muxed by decode
//  ds_rt_value     in   XLEN     store data
//  ds_dest,ds_gr_we in  5,1      destination register / write enable
//  ds_load,ds_store in  1,1      memory op flags
//  ds_mem_size     in   2        0 byte,1 half,2 word
//  ds_pc           in   32       instruction PC
//  ms_allowin      in   1        memory stage accepts
//  es_to_ms_valid  out  1        es_valid && es_ready_go
//  es_result,es_dest,es_gr_we,es_load,es_pc  out XLEN,5,1,1,32  to memory stage
//  data_sram_en    out  1        es_valid && (load||store)
//  data_sram_wen   out  XLEN/8   byte enables
//  data_sram_addr  out  32       ALU result
//  data_sram_wdata out  XLEN     store data replicated per size
//  es_fwd_addr     out  5        es_dest & {5{es_valid && es_gr_we}}
//  es_fwd_data     out  XLEN     es_result
//  es_load_op      out  1        es_valid && es_load (decode must stall, not forward)
//  es_mdu_busy     out  1        mul/div FSM not IDLE
// BEHAVIOUR
//  - Reset: es_valid=0, FSM IDLE, counter=0, HI=LO=0; every output then evaluates to 0 except es_allowin=1.
//  - Capture instruction fields when ds_to_es_valid && es_allowin; es_valid <= ds_to_es_valid whenever es_allowin.
//  - ALU/mfhi/mflo/mt*: single cycle, es_ready_go=1. mfhi/mflo return HI/LO as updated by older instrs.
//  - mult/div FSM IDLE->RUN on first cycle an mdu op is valid in es; RUN counts MUL_LAT/DIV_LAT cycles; DONE (1 cycle)
//    writes HI/LO and raises ready_go; DONE->IDLE when handed to ms. es_ready_go=0 in IDLE/RUN for mdu ops.
//  - mult: {HI,LO} = signed/unsigned 2*XLEN product. div: LO=quotient, HI=remainder (sign of dividend).
//  - Divide by zero: LO=all ones, HI=dividend, same latency, no exception.
//  - Back-to-back mdu ops: second starts only after first leaves DONE; no overlap.
//  - Store wen asserted only when es_valid && store && ms_allowin (issued exactly once);
//    byte: 1<<addr[1:0]; half: 2'b11<<addr[1:0] (addr[1] picks half); word: all ones.
//  - ms_allowin low in DONE: FSM holds DONE, HI/LO written once only.
//  - Async reset mid-RUN aborts the operation; HI/LO keep reset value 0.
// CONFIGURATION
//  EXE_ALIGN_CHK_EN defined: adds out es_ade (1b): es_valid && (load||store) && misaligned (half addr[0], word addr[1:0]);
//    on es_ade store wen forced 0, data_sram_en forced 0, instruction still passes to ms.
//  Undefined: no es_ade port; low address bits only steer byte-enables, no check.
// STRUCTURE
//  - mycpu.h: MDU op codes, MEM size codes, XLEN default, ES_TO_MS_BUS_WD.
//  - Sub-module exe_mdu: FSM, counter, iterative divider, product register, HI/LO; alu reused unchanged.
// TESTING
//  - add 5+7, ms_allowin=1 -> es_result=12 next cycle, es_fwd_addr=dest, no stall.
//  - mult -3*4 then mflo -> 4 cycles es_ready_go=0, LO=0xFFFFFFF4, HI=0xFFFFFFFF, mflo returns 0xFFFFFFF4.
//  - divu 100/7 -> ready_go after 32 cycles, LO=14, HI=2; div 7/0 -> LO=0xFFFFFFFF, HI=7.
//  - sb addr 0x1003 data 0xAB -> wen=4'b1000, wdata=0xABABABAB; sh 0x1002 -> wen=4'b1100.
//  - divu in DONE with ms_allowin=0 for 3 cycles -> FSM stays DONE, HI/LO written once, es_allowin=0.
//  - resetn low mid-RUN -> es_valid=0, es_mdu_busy=0, HI=LO=0 immediately (async).

Source files
------------

// File: rtl/exe_stage_mdu_pkg.sv
// Shared codes for the execute stage: mul/div op codes, memory
// access sizes and mul/div FSM state encodings.
package exe_stage_mdu_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MFHI  = 3'd5;
   localparam logic [2:0] MDU_MFLO  = 3'd6;
   localparam logic [2:0] MDU_MT    = 3'd7;

   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;

   localparam logic [1:0] MDU_IDLE = 2'd0;
   localparam logic [1:0] MDU_RUN  = 2'd1;
   localparam logic [1:0] MDU_DONE = 2'd2;

endpackage

// File: rtl/exe_mdu.sv
// Multi-cycle mul/div unit with HI/LO. Ports: clk, resetn, start
// (mdu op valid in es), op, src1/src2, leave (handed to ms),
// mt_we/mt_hi (mthi/mtlo), hi, lo, busy, done.
module exe_mdu
   import exe_stage_mdu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int MUL_LAT = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            leave,
   input  logic            mt_we,
   input  logic            mt_hi,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done
);

   localparam int LMAX = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
   localparam int CW   = $clog2(LMAX + 1);

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     lat_m1;
   logic [2*XLEN-1:0] prod_q, prod_c;
   logic [XLEN-1:0]   rem_q, quo_q;
   logic [XLEN-1:0]   rem_in, quo_in, rem_nx, quo_nx;
   logic [XLEN-1:0]   abs_a, abs_b, hi_fin, lo_fin;
   logic [XLEN:0]     r_sh, diff;
   logic              is_div, sgn, a_neg, b_neg, idle, finish;

   assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
   assign sgn    = (op == MDU_MULT) || (op == MDU_DIV);
   assign a_neg  = sgn && src1[XLEN-1];
   assign b_neg  = sgn && src2[XLEN-1];
   assign abs_a  = a_neg ? -src1 : src1;
   assign abs_b  = b_neg ? -src2 : src2;
   assign idle   = (state == MDU_IDLE);
   assign lat_m1 = is_div ? CW'(XLEN - 1) : CW'(MUL_LAT - 1);

   assign prod_c = {{XLEN{a_neg}}, src1} * {{XLEN{b_neg}}, src2};

   // One restoring step per cycle; the first step runs in the
   // issue cycle so the whole divide takes exactly XLEN cycles.
   assign rem_in = idle ? '0 : rem_q;
   assign quo_in = idle ? abs_a : quo_q;
   assign r_sh   = {rem_in, quo_in[XLEN-1]};
   assign diff   = r_sh - {1'b0, abs_b};
   assign rem_nx = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_nx = {quo_in[XLEN-2:0], ~diff[XLEN]};

   always_comb begin
      hi_fin = '0;
      lo_fin = '0;
      if (is_div) begin
         if (src2 == '0) begin
            hi_fin = src1;
            lo_fin = '1;
         end else begin
            hi_fin = a_neg ? -rem_nx : rem_nx;
            lo_fin = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
         end
      end else begin
         {hi_fin, lo_fin} = idle ? prod_c : prod_q;
      end
   end

   assign finish = (idle && start && lat_m1 == '0) ||
                   (state == MDU_RUN && cnt == lat_m1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= MDU_IDLE;
         cnt    <= '0;
         prod_q <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
      end else begin
         case (state)
            MDU_IDLE: if (start) begin
               prod_q <= prod_c;
               rem_q  <= rem_nx;
               quo_q  <= quo_nx;
               cnt    <= CW'(1);
               state  <= (lat_m1 == '0) ? MDU_DONE : MDU_RUN;
            end
            MDU_RUN: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt   <= cnt + 1'b1;
               if (cnt == lat_m1) state <= MDU_DONE;
            end
            MDU_DONE: if (leave) begin
               state <= MDU_IDLE;
               cnt   <= '0;
            end
            default: state <= MDU_IDLE;
         endcase
      end
   end

   // Result lands on entry to DONE, so a stall in DONE never
   // rewrites HI/LO.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if (finish) begin
         hi <= hi_fin;
         lo <= lo_fin;
      end else if (mt_we) begin
         if (mt_hi) hi <= src1;
         else       lo <= src1;
      end
   end

   assign busy = !idle;
   assign done = (state == MDU_DONE);

endmodule

// File: rtl/exe_stage_mdu.sv
// Execute stage: ALU, HI/LO mul/div, store byte enables, forwarding.
// Optional EXE_ALIGN_CHK_EN adds es_ade misaligned-access output.
module exe_stage_mdu
   import exe_stage_mdu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int MUL_LAT = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ds_to_es_valid,
   output logic              es_allowin,
   input  logic [11:0]       ds_alu_op,
   input  logic [2:0]        ds_mdu_op,
   input  logic [XLEN-1:0]   ds_src1,
   input  logic [XLEN-1:0]   ds_src2,
   input  logic [XLEN-1:0]   ds_rt_value,
   input  logic [4:0]        ds_dest,
   input  logic              ds_gr_we,
   input  logic              ds_load,
   input  logic              ds_store,
   input  logic [1:0]        ds_mem_size,
   input  logic [31:0]       ds_pc,
   input  logic              ms_allowin,
   output logic              es_to_ms_valid,
   output logic [XLEN-1:0]   es_result,
   output logic [4:0]        es_dest,
   output logic              es_gr_we,
   output logic              es_load,
   output logic [31:0]       es_pc,
   output logic              data_sram_en,
   output logic [XLEN/8-1:0] data_sram_wen,
   output logic [31:0]       data_sram_addr,
   output logic [XLEN-1:0]   data_sram_wdata,
   output logic [4:0]        es_fwd_addr,
   output logic [XLEN-1:0]   es_fwd_data,
   output logic              es_load_op,
   output logic              es_mdu_busy
`ifdef EXE_ALIGN_CHK_EN
   ,
   output logic              es_ade
`endif
);

   localparam int BW = XLEN / 8;
   localparam int SW = $clog2(XLEN);

   logic            es_valid, es_store, es_ready_go;
   logic [11:0]     es_alu_op;
   logic [2:0]      es_mdu_op;
   logic [XLEN-1:0] es_src1, es_src2, es_rt, alu_res, hi, lo;
   logic [1:0]      es_size, addr_lo;
   logic [BW-1:0]   be;
   logic            md_op, mdu_done, ade;
   logic [SW-1:0]   sa;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         es_valid  <= 1'b0;
         es_alu_op <= '0;
         es_mdu_op <= '0;
         es_src1   <= '0;
         es_src2   <= '0;
         es_rt     <= '0;
         es_dest   <= '0;
         es_gr_we  <= 1'b0;
         es_load   <= 1'b0;
         es_store  <= 1'b0;
         es_size   <= '0;
         es_pc     <= '0;
      end else begin
         if (es_allowin) es_valid <= ds_to_es_valid;
         if (ds_to_es_valid && es_allowin) begin
            es_alu_op <= ds_alu_op;
            es_mdu_op <= ds_mdu_op;
            es_src1   <= ds_src1;
            es_src2   <= ds_src2;
            es_rt     <= ds_rt_value;
            es_dest   <= ds_dest;
            es_gr_we  <= ds_gr_we;
            es_load   <= ds_load;
            es_store  <= ds_store;
            es_size   <= ds_mem_size;
            es_pc     <= ds_pc;
         end
      end
   end

   assign sa = es_src1[SW-1:0];

   always_comb begin
      alu_res = '0;
      unique case (1'b1)
         es_alu_op[0]:  alu_res = es_src1 + es_src2;
         es_alu_op[1]:  alu_res = es_src1 - es_src2;
         es_alu_op[2]:  alu_res = XLEN'($signed(es_src1) < $signed(es_src2));
         es_alu_op[3]:  alu_res = XLEN'(es_src1 < es_src2);
         es_alu_op[4]:  alu_res = es_src1 & es_src2;
         es_alu_op[5]:  alu_res = ~(es_src1 | es_src2);
         es_alu_op[6]:  alu_res = es_src1 | es_src2;
         es_alu_op[7]:  alu_res = es_src1 ^ es_src2;
         es_alu_op[8]:  alu_res = es_src2 << sa;
         es_alu_op[9]:  alu_res = es_src2 >> sa;
         es_alu_op[10]: alu_res = $signed(es_src2) >>> sa;
         es_alu_op[11]: alu_res = {es_src2[15:0], {(XLEN-16){1'b0}}};
         default:       alu_res = '0;
      endcase
   end

   assign md_op = (es_mdu_op == MDU_MULT) || (es_mdu_op == MDU_MULTU) ||
                  (es_mdu_op == MDU_DIV)  || (es_mdu_op == MDU_DIVU);

   exe_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_mdu (
      .clk    (clk),
      .resetn (resetn),
      .start  (es_valid && md_op),
      .op     (es_mdu_op),
      .src1   (es_src1),
      .src2   (es_src2),
      .leave  (es_valid && ms_allowin),
      .mt_we  (es_valid && es_mdu_op == MDU_MT && ms_allowin),
      .mt_hi  (es_dest[0]),
      .hi     (hi),
      .lo     (lo),
      .busy   (es_mdu_busy),
      .done   (mdu_done)
   );

   assign es_ready_go    = !md_op || mdu_done;
   assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid && es_ready_go;

   always_comb begin
      es_result = alu_res;
      if (es_mdu_op == MDU_MFHI) es_result = hi;
      if (es_mdu_op == MDU_MFLO) es_result = lo;
   end

   assign addr_lo = alu_res[1:0];

`ifdef EXE_ALIGN_CHK_EN
   assign ade = es_valid && (es_load || es_store) &&
                ((es_size == MEM_H && addr_lo[0]) ||
                 (es_size != MEM_B && es_size != MEM_H && addr_lo != 2'b00));
   assign es_ade = ade;
`else
   assign ade = 1'b0;
`endif

   always_comb begin
      be              = '1;
      data_sram_wdata = es_rt;
      case (es_size)
         MEM_B: begin
            be              = BW'(1) << addr_lo;
            data_sram_wdata = {BW{es_rt[7:0]}};
         end
         MEM_H: begin
            be              = BW'(3) << addr_lo;
            data_sram_wdata = XLEN'({BW{es_rt[15:0]}});
         end
         default: ;
      endcase
   end

   assign data_sram_en   = es_valid && (es_load || es_store) && !ade;
   assign data_sram_wen  = (es_valid && es_store && ms_allowin && !ade) ?
                           be : '0;
   assign data_sram_addr = 32'(alu_res);

   assign es_fwd_addr = es_dest & {5{es_valid && es_gr_we}};
   assign es_fwd_data = es_result;
   assign es_load_op  = es_valid && es_load;

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed bench for exe_stage_mdu: ALU/store vectors from a table,
// then hand sequences for mul/div latency, DONE stall and reset.
module tb_exe_stage_mdu;
   import exe_stage_mdu_pkg::*;

   localparam logic [11:0] OP_ADD = 12'h001;
   localparam logic [11:0] OP_SUB = 12'h002;
   localparam logic [11:0] OP_OR  = 12'h040;
   localparam logic [11:0] OP_SLL = 12'h100;
   localparam logic [11:0] OP_SRA = 12'h400;
   localparam logic [11:0] OP_LUI = 12'h800;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ds_to_es_valid, es_allowin;
   logic [11:0] ds_alu_op;
   logic [2:0]  ds_mdu_op;
   logic [31:0] ds_src1, ds_src2, ds_rt_value, ds_pc;
   logic [4:0]  ds_dest;
   logic        ds_gr_we, ds_load, ds_store;
   logic [1:0]  ds_mem_size;
   logic        ms_allowin, es_to_ms_valid;
   logic [31:0] es_result, es_pc, data_sram_addr, data_sram_wdata;
   logic [4:0]  es_dest, es_fwd_addr;
   logic        es_gr_we, es_load, data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] es_fwd_data;
   logic        es_load_op, es_mdu_busy;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] pc_n = 32'h1c00_0000;

   exe_stage_mdu dut (
      .clk             (clk),
      .resetn          (resetn),
      .ds_to_es_valid  (ds_to_es_valid),
      .es_allowin      (es_allowin),
      .ds_alu_op       (ds_alu_op),
      .ds_mdu_op       (ds_mdu_op),
      .ds_src1         (ds_src1),
      .ds_src2         (ds_src2),
      .ds_rt_value     (ds_rt_value),
      .ds_dest         (ds_dest),
      .ds_gr_we        (ds_gr_we),
      .ds_load         (ds_load),
      .ds_store        (ds_store),
      .ds_mem_size     (ds_mem_size),
      .ds_pc           (ds_pc),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_result       (es_result),
      .es_dest         (es_dest),
      .es_gr_we        (es_gr_we),
      .es_load         (es_load),
      .es_pc           (es_pc),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .es_fwd_addr     (es_fwd_addr),
      .es_fwd_data     (es_fwd_data),
      .es_load_op      (es_load_op),
      .es_mdu_busy     (es_mdu_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] alu;
      logic [31:0] s1, s2, rt;
      logic [4:0]  d;
      logic        we, ld, st;
      logic [1:0]  sz;
      logic [31:0] e_res;
      logic [3:0]  e_wen;
      logic [31:0] e_wdata;
      logic        e_en;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [11:0] a, input logic [2:0] m,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] rt, input logic [4:0] d,
                        input logic we, input logic ld, input logic st,
                        input logic [1:0] sz);
      ds_to_es_valid = 1'b1;
      ds_alu_op      = a;
      ds_mdu_op      = m;
      ds_src1        = s1;
      ds_src2        = s2;
      ds_rt_value    = rt;
      ds_dest        = d;
      ds_gr_we       = we;
      ds_load        = ld;
      ds_store       = st;
      ds_mem_size    = sz;
      ds_pc          = pc_n;
      pc_n           = pc_n + 32'd4;
   endtask

   // Counts stalled cycles from issue until es_to_ms_valid rises.
   task automatic wait_go(output int n);
      n = 0;
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      while (!es_to_ms_valid && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic md_seq(input string nm, input logic [2:0] m,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input int e_n, input logic [31:0] e_hi,
                         input logic [31:0] e_lo);
      int n;
      @(negedge clk);
      drive(12'h0, m, s1, s2, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2);
      wait_go(n);
      chk({nm, "_stall"}, 64'(n), 64'(e_n));
      chk({nm, "_busy_done"}, 64'(es_mdu_busy), 64'd1);
      drive(12'h0, MDU_MFLO, 0, 0, 0, 5'd2, 1'b1, 1'b0, 1'b0, 2'd2);
      @(negedge clk);
      chk({nm, "_lo"}, 64'(es_result), 64'(e_lo));
      chk({nm, "_idle"}, 64'(es_mdu_busy), 64'd0);
      drive(12'h0, MDU_MFHI, 0, 0, 0, 5'd2, 1'b1, 1'b0, 1'b0, 2'd2);
      @(negedge clk);
      chk({nm, "_hi"}, 64'(es_result), 64'(e_hi));
      ds_to_es_valid = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] pc_e;

      vt[0]  = '{OP_ADD, 32'd5, 32'd7, 32'h0, 5'd3, 1, 0, 0, 2'd2,
                 32'd12, 4'h0, 32'h0, 0};
      vt[1]  = '{OP_SUB, 32'd5, 32'd7, 32'h0, 5'd4, 1, 0, 0, 2'd2,
                 32'hFFFF_FFFE, 4'h0, 32'h0, 0};
      vt[2]  = '{OP_OR, 32'hF0F0, 32'h0F00, 32'h0, 5'd5, 1, 0, 0, 2'd2,
                 32'hFFF0, 4'h0, 32'h0, 0};
      vt[3]  = '{OP_SLL, 32'd4, 32'd1, 32'h0, 5'd6, 1, 0, 0, 2'd2,
                 32'h10, 4'h0, 32'h0, 0};
      vt[4]  = '{OP_LUI, 32'd0, 32'h1234, 32'h0, 5'd8, 1, 0, 0, 2'd2,
                 32'h1234_0000, 4'h0, 32'h0, 0};
      vt[5]  = '{OP_SRA, 32'd2, 32'hFFFF_FFF0, 32'h0, 5'd9, 1, 0, 0,
                 2'd2, 32'hFFFF_FFFC, 4'h0, 32'h0, 0};
      vt[6]  = '{OP_ADD, 32'h1000, 32'd3, 32'hAB, 5'd0, 0, 0, 1, 2'd0,
                 32'h1003, 4'b1000, 32'hABAB_ABAB, 1};
      vt[7]  = '{OP_ADD, 32'h1000, 32'd2, 32'h1234, 5'd0, 0, 0, 1, 2'd1,
                 32'h1002, 4'b1100, 32'h1234_1234, 1};
      vt[8]  = '{OP_ADD, 32'h1000, 32'd4, 32'hDEAD_BEEF, 5'd0, 0, 0, 1,
                 2'd2, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 1};
      vt[9]  = '{OP_ADD, 32'h1000, 32'd0, 32'h5A, 5'd0, 0, 0, 1, 2'd0,
                 32'h1000, 4'b0001, 32'h5A5A_5A5A, 1};
      vt[10] = '{OP_ADD, 32'h2000, 32'd8, 32'h0, 5'd7, 1, 1, 0, 2'd2,
                 32'h2008, 4'h0, 32'h0, 1};

      resetn     = 1'b0;
      ms_allowin = 1'b1;
      drive(12'h0, 3'd0, 0, 0, 0, 5'd0, 0, 0, 0, 2'd0);
      ds_to_es_valid = 1'b0;
      #12;
      chk("rst_to_ms", 64'(es_to_ms_valid), 64'd0);
      chk("rst_allowin", 64'(es_allowin), 64'd1);
      chk("rst_result", 64'(es_result), 64'd0);
      chk("rst_busy", 64'(es_mdu_busy), 64'd0);
      chk("rst_en", 64'(data_sram_en), 64'd0);
      chk("rst_wen", 64'(data_sram_wen), 64'd0);
      chk("rst_fwd", 64'(es_fwd_addr), 64'd0);
      chk("rst_pc", 64'(es_pc), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         pc_e = pc_n;
         drive(vt[i].alu, 3'd0, vt[i].s1, vt[i].s2, vt[i].rt, vt[i].d,
               vt[i].we, vt[i].ld, vt[i].st, vt[i].sz);
         @(negedge clk);
         ds_to_es_valid = 1'b0;
         chk($sformatf("v%0d_to_ms", i), 64'(es_to_ms_valid), 64'd1);
         chk($sformatf("v%0d_allowin", i), 64'(es_allowin), 64'd1);
         chk($sformatf("v%0d_res", i), 64'(es_result), 64'(vt[i].e_res));
         chk($sformatf("v%0d_fwd_data", i), 64'(es_fwd_data),
             64'(vt[i].e_res));
         chk($sformatf("v%0d_fwd_addr", i), 64'(es_fwd_addr),
             64'(vt[i].we ? vt[i].d : 5'd0));
         chk($sformatf("v%0d_wen", i), 64'(data_sram_wen),
             64'(vt[i].e_wen));
         chk($sformatf("v%0d_wdata", i), 64'(data_sram_wdata),
             64'(vt[i].e_wdata));
         chk($sformatf("v%0d_en", i), 64'(data_sram_en), 64'(vt[i].e_en));
         chk($sformatf("v%0d_load_op", i), 64'(es_load_op),
             64'(vt[i].ld));
         chk($sformatf("v%0d_pc", i), 64'(es_pc), 64'(pc_e));
      end

      @(negedge clk);
      ms_allowin = 1'b0;
      drive(OP_ADD, 3'd0, 32'h1000, 32'd8, 32'h1111_2222, 5'd0,
            0, 0, 1, 2'd2);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      chk("sw_hold_wen", 64'(data_sram_wen), 64'h0);
      chk("sw_hold_en", 64'(data_sram_en), 64'd1);
      chk("sw_hold_allowin", 64'(es_allowin), 64'd0);
      ms_allowin = 1'b1;
      #1;
      chk("sw_go_wen", 64'(data_sram_wen), 64'hF);

      md_seq("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd4, 4,
             32'hFFFF_FFFF, 32'hFFFF_FFF4);
      md_seq("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 4,
             32'h1, 32'hFFFF_FFFE);
      md_seq("divu", MDU_DIVU, 32'd100, 32'd7, 32, 32'd2, 32'd14);
      md_seq("div0", MDU_DIV, 32'd7, 32'd0, 32, 32'd7, 32'hFFFF_FFFF);
      md_seq("divneg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);

      @(negedge clk);
      drive(12'h0, MDU_MT, 32'h55, 0, 0, 5'd1, 0, 0, 0, 2'd2);
      @(negedge clk);
      drive(12'h0, MDU_MFHI, 0, 0, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      chk("mthi_mfhi", 64'(es_result), 64'h55);
      drive(12'h0, MDU_MT, 32'h66, 0, 0, 5'd0, 0, 0, 0, 2'd2);
      @(negedge clk);
      drive(12'h0, MDU_MFLO, 0, 0, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      chk("mtlo_mflo", 64'(es_result), 64'h66);
      ds_to_es_valid = 1'b0;

      @(negedge clk);
      ms_allowin = 1'b0;
      drive(12'h0, MDU_DIVU, 32'd50, 32'd6, 0, 5'd0, 0, 0, 0, 2'd2);
      wait_go(n);
      chk("hold_stall", 64'(n), 64'd32);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("hold%0d_allowin", k), 64'(es_allowin), 64'd0);
         chk($sformatf("hold%0d_busy", k), 64'(es_mdu_busy), 64'd1);
         chk($sformatf("hold%0d_to_ms", k), 64'(es_to_ms_valid), 64'd1);
         @(negedge clk);
      end
      ms_allowin = 1'b1;
      drive(12'h0, MDU_MFLO, 0, 0, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      chk("hold_lo", 64'(es_result), 64'd8);
      chk("hold_idle", 64'(es_mdu_busy), 64'd0);
      drive(12'h0, MDU_MFHI, 0, 0, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      chk("hold_hi", 64'(es_result), 64'd2);
      ds_to_es_valid = 1'b0;

      @(negedge clk);
      drive(12'h0, MDU_DIVU, 32'd100, 32'd7, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("run_busy", 64'(es_mdu_busy), 64'd1);
      chk("run_fwd", 64'(es_fwd_addr), 64'd2);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_busy", 64'(es_mdu_busy), 64'd0);
      chk("arst_to_ms", 64'(es_to_ms_valid), 64'd0);
      chk("arst_allowin", 64'(es_allowin), 64'd1);
      chk("arst_fwd", 64'(es_fwd_addr), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      drive(12'h0, MDU_MFHI, 0, 0, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      chk("arst_hi", 64'(es_result), 64'd0);
      drive(12'h0, MDU_MFLO, 0, 0, 0, 5'd2, 1, 0, 0, 2'd2);
      @(negedge clk);
      chk("arst_lo", 64'(es_result), 64'd0);
      ds_to_es_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
